xintf_snap_read_ctrl: RTL and testbench

//  Read-side controller for the DSP XINTF mailbox window at 0x0FD05..0x0FD09.
//  A DSP read of the first word takes an atomic snapshot of all four FPGA->DSP

---
 rtl/xintf_snap_read_ctrl.sv | 162 ++++++++++++++++
 tb/tb_xintf_snap_read_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xintf_snap_read_ctrl.sv
// DSP XINTF mailbox read controller: a word0 read takes an atomic snapshot of four source words.
// Optional macro XINTF_SNAP_SEQ_EN builds an 8-bit snapshot sequence counter reported in status[15:8].
module xintf_snap_read_ctrl #(
    parameter logic [19:0] BASE_ADDR    = 20'h0FD05,
    parameter int          MAX_WAIT     = 8,
    parameter int          HOLD_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        global_rst,
    input  logic        ren,
    input  logic [19:0] xadd,
    input  logic [63:0] src_data,
    input  logic        src_busy,
    output logic [15:0] rd_data,
    output logic        rd_oe,
    output logic        snap_active,
    output logic        stale
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SRC, S_CAPTURE, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic          ren_m_q, ren_s_q, ren_p_q;
    logic [19:0]   addr_q;
    logic [WW-1:0] wait_q, wait_d;
    logic [HW-1:0] idle_q, idle_d;
    logic          force_q, force_d;
    logic          stale_q;
    logic [63:0]   snap_q;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_oe_q;
    logic [7:0]    seq_w;

    logic       rd_start, rd_end, in_win, is_w0, is_w3, snap_req, data_ok;
    logic [2:0] off;

    assign rd_start = ren_p_q & ~ren_s_q;
    assign rd_end   = ~ren_p_q & ren_s_q;
    assign in_win   = (addr_q >= BASE_ADDR) && (addr_q <= BASE_ADDR + 20'd4);
    assign is_w0    = (addr_q == BASE_ADDR);
    assign is_w3    = (addr_q == BASE_ADDR + 20'd3);
    // Low three bits suffice: the in-window offset is 0..4, so the subtraction mod 8 is exact.
    assign off      = addr_q[2:0] - BASE_ADDR[2:0];
    assign snap_req = rd_start && is_w0 && (state_q == S_IDLE || state_q == S_HOLD);
    // The request cycle itself is also blocked so the pad never flashes the previous snapshot.
    assign data_ok  = !(state_q == S_WAIT_SRC || state_q == S_CAPTURE) && !snap_req;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idle_d  = idle_q;
        force_d = force_q;
        unique case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    state_d = S_WAIT_SRC;
                    wait_d  = '0;
                    force_d = 1'b0;
                end
            end
            S_WAIT_SRC: begin
                // Timeout wins over a simultaneous src_busy drop, so that case is flagged stale.
                if (wait_q == WW'(MAX_WAIT)) begin
                    force_d = 1'b1;
                    state_d = S_CAPTURE;
                end else if (!src_busy) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_HOLD;
                idle_d  = '0;
            end
            S_HOLD: begin
                if (rd_start)
                    idle_d = '0;
                else if (idle_q != HW'(HOLD_TIMEOUT))
                    idle_d = idle_q + 1'b1;
                if (snap_req) begin
                    state_d = S_WAIT_SRC;
                    wait_d  = '0;
                    force_d = 1'b0;
                end else if (rd_end && is_w3) begin
                    state_d = S_IDLE;
                end else if (!rd_start && idle_q == HW'(HOLD_TIMEOUT)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign snap_active = (state_q != S_IDLE);

    always_comb begin
        rd_data_d = rd_data_q;
        if (!ren_s_q && in_win) begin
            case (off)
                3'd0:    rd_data_d = snap_q[15:0];
                3'd1:    rd_data_d = snap_q[31:16];
                3'd2:    rd_data_d = snap_q[47:32];
                3'd3:    rd_data_d = snap_q[63:48];
                3'd4:    rd_data_d = {seq_w, 5'b0, stale_q, 1'b0, snap_active};
                default: rd_data_d = rd_data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            ren_m_q   <= 1'b1;
            ren_s_q   <= 1'b1;
            ren_p_q   <= 1'b1;
            addr_q    <= '0;
            state_q   <= S_IDLE;
            wait_q    <= '0;
            idle_q    <= '0;
            force_q   <= 1'b0;
            stale_q   <= 1'b0;
            snap_q    <= '0;
            rd_data_q <= '0;
            rd_oe_q   <= 1'b0;
        end else begin
            ren_m_q   <= ren;
            ren_s_q   <= ren_m_q;
            ren_p_q   <= ren_s_q;
            addr_q    <= xadd;
            state_q   <= state_d;
            wait_q    <= wait_d;
            idle_q    <= idle_d;
            force_q   <= force_d;
            rd_data_q <= rd_data_d;
            rd_oe_q   <= ~ren_s_q & in_win & data_ok;
            if (state_q == S_CAPTURE) begin
                snap_q  <= src_data;
                stale_q <= force_q;
            end
        end
    end

`ifdef XINTF_SNAP_SEQ_EN
    logic [7:0] seq_q;
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst)
            seq_q <= '0;
        else if (state_q == S_CAPTURE)
            seq_q <= seq_q + 8'd1;
    end
    assign seq_w = seq_q;
`else
    assign seq_w = 8'h00;
`endif

    assign rd_data = rd_data_q;
    assign rd_oe   = rd_oe_q;
    assign stale   = stale_q;

endmodule

// File: tb/tb_xintf_snap_read_ctrl.sv
// Self-checking bench for xintf_snap_read_ctrl: table vectors, directed corners, random reads vs model.
module tb_xintf_snap_read_ctrl;
    localparam logic [19:0] BASE     = 20'h0FD05;
    localparam int          MAX_WAIT = 8;
`ifdef XINTF_SNAP_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        global_rst, ren, src_busy;
    logic [19:0] xadd;
    logic [63:0] src_data;
    logic [15:0] rd_data;
    logic        rd_oe, snap_active, stale;

    xintf_snap_read_ctrl dut (
        .clk(clk), .global_rst(global_rst), .ren(ren), .xadd(xadd),
        .src_data(src_data), .src_busy(src_busy), .rd_data(rd_data),
        .rd_oe(rd_oe), .snap_active(snap_active), .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the DSP should see, by the read-protocol rules only.
    logic [15:0] m_snap[4];
    logic [7:0]  m_seq;
    bit          m_stale, m_active;
    logic [15:0] m_last;

    typedef struct {
        int          off;
        logic [15:0] exp_d;
        bit          exp_act;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] status_exp();
        return {(SEQ_EN ? m_seq : 8'h00), 5'b0, m_stale, 1'b0, m_active};
    endfunction

    task automatic model_capture(input bit forced);
        for (int i = 0; i < 4; i++) m_snap[i] = src_data[16*i +: 16];
        m_stale  = forced;
        m_seq    = m_seq + 8'd1;
        m_active = 1'b1;
    endtask

    task automatic start_read(input logic [19:0] a);
        @(negedge clk);
        xadd = a;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic wait_oe(output int lat);
        lat = 0;
        while (!rd_oe && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rd_oe within bound", rd_oe, 1'b1);
    endtask

    task automatic end_read(output logic [15:0] d);
        d = rd_data;
        @(negedge clk);
        ren = 1'b1;
        repeat (4) @(negedge clk);
        chk("rd_oe released", rd_oe, 1'b0);
    endtask

    task automatic raw_read(input logic [19:0] a, output logic [15:0] d, output int lat);
        start_read(a);
        wait_oe(lat);
        end_read(d);
    endtask

    task automatic do_read(input int off, input bit forced);
        logic [15:0] d, exp;
        int lat;
        if (forced) src_busy = 1'b1;
        raw_read(BASE + 20'(off), d, lat);
        src_busy = 1'b0;
        if (off == 0) model_capture(forced);
        exp = (off < 4) ? m_snap[off] : status_exp();
        if (off == 3) m_active = 1'b0;
        chk($sformatf("read+%0d data", off), d, exp);
        chk($sformatf("read+%0d snap_active", off), snap_active, m_active);
        chk($sformatf("read+%0d stale", off), stale, m_stale);
        if (forced) chk("forced capture latency", lat >= MAX_WAIT + 3, 1'b1);
        m_last = exp;
    endtask

    // Word0 read where src_busy drops `rel` clk edges after ren falls.
    task automatic edge_read(input int rel, input bit exp_forced);
        logic [15:0] d;
        int lat;
        src_data = {$urandom, $urandom};
        src_busy = 1'b1;
        start_read(BASE);
        repeat (rel) @(posedge clk);
        #1 src_busy = 1'b0;
        wait_oe(lat);
        end_read(d);
        model_capture(exp_forced);
        m_last = m_snap[0];
        chk($sformatf("edge%0d word0", rel), d, m_snap[0]);
        chk($sformatf("edge%0d stale", rel), stale, exp_forced);
        do_read(4, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_snap[i] = '0;
        m_seq = '0; m_stale = 1'b0; m_active = 1'b0; m_last = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int lat;
        global_rst = 1'b1; ren = 1'b1; xadd = '0; src_data = '0; src_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset rd_data", rd_data, 16'h0);
        chk("reset rd_oe", rd_oe, 1'b0);
        chk("reset snap_active", snap_active, 1'b0);
        chk("reset stale", stale, 1'b0);
        global_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic coherent read of the window.
        src_data = {16'd4, 16'd3, 16'd2, 16'd1};
        tbl[0] = '{0, 16'd1, 1'b1};
        tbl[1] = '{1, 16'd2, 1'b1};
        tbl[2] = '{2, 16'd3, 1'b1};
        tbl[3] = '{4, (SEQ_EN ? 16'h0101 : 16'h0001), 1'b1};
        tbl[4] = '{3, 16'd4, 1'b0};
        for (int i = 0; i < 5; i++) begin
            raw_read(BASE + 20'(tbl[i].off), d, lat);
            chk($sformatf("tbl%0d data", i), d, tbl[i].exp_d);
            chk($sformatf("tbl%0d snap_active", i), snap_active, tbl[i].exp_act);
            chk($sformatf("tbl%0d stale", i), stale, 1'b0);
        end
        for (int i = 0; i < 4; i++) m_snap[i] = 16'(i + 1);
        m_seq = 8'd1; m_last = 16'd4;

        // Capture waits for src_busy to fall, then sees the post-update set.
        src_data = 64'h1111_2222_3333_4444;
        src_busy = 1'b1;
        start_read(BASE);
        repeat (5) @(posedge clk);
        #1 src_data = 64'hAAAA_BBBB_CCCC_DDDD;
        src_busy = 1'b0;
        wait_oe(lat);
        end_read(d);
        model_capture(1'b0);
        chk("busy-wait word0", d, 16'hDDDD);
        chk("busy-wait stale", stale, 1'b0);
        do_read(1, 1'b0);
        src_data = 64'h5555_6666_7777_8888;
        do_read(2, 1'b0);
        do_read(3, 1'b0);

        // Forced capture with src_busy stuck high.
        do_read(0, 1'b1);
        do_read(4, 1'b0);

        // src_busy falling just before vs exactly at the wait limit.
        edge_read(10, 1'b0);
        edge_read(11, 1'b1);

        // Out-of-window read: no drive, data held.
        start_read(BASE + 20'd5);
        repeat (8) @(negedge clk);
        chk("out-of-window rd_oe", rd_oe, 1'b0);
        chk("out-of-window rd_data held", rd_data, m_last);
        end_read(d);

        // HOLD timeout releases the snapshot but keeps its contents.
        src_data = {$urandom, $urandom};
        do_read(0, 1'b0);
        src_data = {$urandom, $urandom};
        repeat (500) @(negedge clk);
        chk("hold before timeout", snap_active, 1'b1);
        repeat (600) @(negedge clk);
        m_active = 1'b0;
        chk("hold after timeout", snap_active, 1'b0);
        do_read(1, 1'b0);

        // Reset in the middle of a waited capture.
        src_busy = 1'b1;
        start_read(BASE);
        repeat (5) @(negedge clk);
        global_rst = 1'b1;
        @(negedge clk);
        chk("midreset snap_active", snap_active, 1'b0);
        chk("midreset rd_oe", rd_oe, 1'b0);
        chk("midreset stale", stale, 1'b0);
        chk("midreset rd_data", rd_data, 16'h0);
        ren = 1'b1; src_busy = 1'b0;
        @(negedge clk);
        global_rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        do_read(2, 1'b0);
        do_read(4, 1'b0);

        // Random read traffic against the model.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 5);
            src_data = {$urandom, $urandom};
            case (op)
                0:       do_read(0, 1'b0);
                1:       do_read(0, 1'b1);
                5:       do_read(4, 1'b0);
                default: do_read(op - 1, 1'b0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
